t05_cb_walker: RTL and testbench

//  Parametrised codebook generator: depth-first walk of the Huffman tree in SRAM; one (symbol, code, length) record per leaf.

---
 rtl/t05_cb_walker_if.sv | 34 +++
 rtl/t05_cb_walker.sv | 194 +++++++++++++++++++
 tb/tb_t05_cb_walker.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/t05_cb_walker_if.sv
// Node-memory read port and codebook record stream shared by the tree walker and its neighbours.
interface t05_cb_walker_if #(
  parameter int unsigned IDX_W   = 7,
  parameter int unsigned PAY_W   = 8,
  parameter int unsigned MAX_LEN = 32
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic               node_req;
  logic [IDX_W-1:0]   node_idx;
  logic               node_ack;
  logic [PAY_W:0]     node_left;
  logic [PAY_W:0]     node_right;

  logic               code_valid;
  logic               code_ready;
  logic [PAY_W-1:0]   code_sym;
  logic [MAX_LEN-1:0] code_bits;
  logic [LEN_W-1:0]   code_len;

  modport master (
    output node_req, node_idx,
    input  node_ack, node_left, node_right,
    output code_valid, code_sym, code_bits, code_len,
    input  code_ready
  );

  modport slave (
    input  node_req, node_idx,
    output node_ack, node_left, node_right,
    input  code_valid, code_sym, code_bits, code_len,
    output code_ready
  );
endinterface

// File: rtl/t05_cb_walker.sv
// Depth-first Huffman codebook walker: fetches each tree node once, keeps pending
// right siblings on a stack and emits one (symbol, code, length) record per leaf.
module t05_cb_walker #(
  parameter int unsigned IDX_W   = 7,
  parameter int unsigned PAY_W   = 8,
  parameter int unsigned MAX_LEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] root_idx,
  t05_cb_walker_if.master  bus,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned SP_W  = $clog2(MAX_LEN);
  localparam logic [PAY_W:0] NULL_CHILD = {1'b1, 1'b1, {(PAY_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EVAL, S_EMIT, S_POP, S_DONE, S_ERR
  } state_t;

  // Pending right sibling and the depth it sits at.
  typedef struct packed {
    logic [PAY_W:0]   child;
    logic [LEN_W-1:0] depth;
  } entry_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   node_idx_q, node_idx_d;
  logic [PAY_W:0]     left_q, left_d;
  logic [PAY_W:0]     right_q, right_d;
  logic [MAX_LEN-1:0] bits_q, bits_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   sp_q, sp_d;
  logic [PAY_W-1:0]   sym_q, sym_d;
  logic               err_q, err_d;
  logic               node_req_q, code_valid_q, busy_q, done_q;

  entry_t             stack_mem [MAX_LEN];
  entry_t             push_entry, top;
  logic               push_en;
  logic [LEN_W-1:0]   pop_idx;
  logic [LEN_W-1:0]   shamt;
  logic               l_null, r_null;

  assign l_null  = (left_q == NULL_CHILD);
  assign r_null  = (right_q == NULL_CHILD);
  assign pop_idx = (sp_q == '0) ? '0 : LEN_W'(sp_q - LEN_W'(1));
  assign top     = stack_mem[SP_W'(pop_idx)];
  assign shamt   = LEN_W'(len_q - top.depth + LEN_W'(1));

  // Next-state and datapath decisions.
  always_comb begin
    state_d    = state_q;
    node_idx_d = node_idx_q;
    left_d     = left_q;
    right_d    = right_q;
    bits_d     = bits_q;
    len_d      = len_q;
    sp_d       = sp_q;
    sym_d      = sym_q;
    err_d      = err_q;
    push_en    = 1'b0;
    push_entry = '{child: right_q, depth: LEN_W'(len_q + LEN_W'(1))};

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d      = 1'b0;
          len_d      = '0;
          bits_d     = '0;
          sp_d       = '0;
          node_idx_d = root_idx;
          state_d    = S_FETCH;
        end
      end

      S_FETCH: begin
        if (node_req_q && bus.node_ack) begin
          left_d  = bus.node_left;
          right_d = bus.node_right;
          state_d = S_EVAL;
        end
      end

      S_EVAL: begin
        if (len_q == LEN_W'(MAX_LEN) && (!l_null || !r_null)) begin
          state_d = S_ERR;
        end else if (!r_null && sp_q == LEN_W'(MAX_LEN)) begin
          state_d = S_ERR;
        end else begin
          if (!r_null) begin
            push_en = 1'b1;
            sp_d    = LEN_W'(sp_q + LEN_W'(1));
          end
          if (l_null) begin
            state_d = S_POP;
          end else begin
            bits_d = {bits_q[MAX_LEN-2:0], 1'b0};
            len_d  = LEN_W'(len_q + LEN_W'(1));
            if (left_q[PAY_W]) begin
              node_idx_d = left_q[IDX_W-1:0];
              state_d    = S_FETCH;
            end else begin
              sym_d   = left_q[PAY_W-1:0];
              state_d = S_EMIT;
            end
          end
        end
      end

      S_EMIT: begin
        if (code_valid_q && bus.code_ready) state_d = S_POP;
      end

      // Rewind the path to the sibling's parent, then take the right branch.
      S_POP: begin
        if (sp_q == '0) begin
          state_d = S_DONE;
        end else begin
          sp_d   = pop_idx;
          bits_d = ((bits_q >> shamt) << 1) | MAX_LEN'(1);
          len_d  = top.depth;
          if (top.child[PAY_W]) begin
            node_idx_d = top.child[IDX_W-1:0];
            state_d    = S_FETCH;
          end else begin
            sym_d   = top.child[PAY_W-1:0];
            state_d = S_EMIT;
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ERR) err_d = 1'b1;
  end

  // Control state, path registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      node_idx_q   <= '0;
      left_q       <= '0;
      right_q      <= '0;
      bits_q       <= '0;
      len_q        <= '0;
      sp_q         <= '0;
      sym_q        <= '0;
      err_q        <= 1'b0;
      node_req_q   <= 1'b0;
      code_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      node_idx_q   <= node_idx_d;
      left_q       <= left_d;
      right_q      <= right_d;
      bits_q       <= bits_d;
      len_q        <= len_d;
      sp_q         <= sp_d;
      sym_q        <= sym_d;
      err_q        <= err_d;
      node_req_q   <= (state_d == S_FETCH);
      code_valid_q <= (state_d == S_EMIT);
      busy_q       <= (state_d != S_IDLE) && (state_d != S_ERR);
      done_q       <= (state_d == S_DONE);
    end
  end

  // Stack storage needs no reset: entries above sp are never read.
  always_ff @(posedge clk) begin
    if (push_en) stack_mem[SP_W'(sp_q)] <= push_entry;
  end

  assign bus.node_req   = node_req_q;
  assign bus.node_idx   = node_idx_q;
  assign bus.code_valid = code_valid_q;
  assign bus.code_sym   = sym_q;
  assign bus.code_bits  = bits_q;
  assign bus.code_len   = len_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_t05_cb_walker.sv
// Directed bench for t05_cb_walker: a node-memory responder and record sink per instance,
// with hand-computed record streams and node fetch orders.
module tb_t05_cb_walker;

  localparam logic [8:0] NUL = 9'h180;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start4;
  logic [6:0] root_idx;
  logic       busy, done, err;
  logic       busy4, done4, err4;

  t05_cb_walker_if #(.IDX_W(7), .PAY_W(8), .MAX_LEN(32)) if0 ();
  t05_cb_walker_if #(.IDX_W(7), .PAY_W(8), .MAX_LEN(4))  if4 ();

  t05_cb_walker #(.IDX_W(7), .PAY_W(8), .MAX_LEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .root_idx(root_idx),
    .bus(if0.master), .busy(busy), .done(done), .err(err)
  );

  t05_cb_walker #(.IDX_W(7), .PAY_W(8), .MAX_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .root_idx(root_idx),
    .bus(if4.master), .busy(busy4), .done(done4), .err(err4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [7:0] s, input logic [31:0] b, input logic [5:0] l);
    return {18'd0, s, b, l};
  endfunction

  function automatic logic [8:0] nd(input int i);
    return {1'b1, 8'(i)};
  endfunction

  function automatic logic [8:0] sy(input logic [7:0] s);
    return {1'b0, s};
  endfunction

  logic [8:0] mem_l [0:127];
  logic [8:0] mem_r [0:127];

  logic [63:0] rec_q [$];
  logic [6:0]  idx_q [$];
  logic [14:0] rec4_q [$];

  bit   rand_dly = 1'b0;
  int   wait_cnt, idx_unstable;
  logic req_prev;
  logic [6:0] req_idx;

  // Node memory for the main instance: variable ack delay, node_idx stability monitor.
  initial begin
    if0.node_ack = 1'b0; if0.node_left = '0; if0.node_right = '0;
    wait_cnt = 0; idx_unstable = 0; req_prev = 1'b0; req_idx = '0;
    forever begin
      @(negedge clk);
      if0.node_ack = 1'b0;
      if (if0.node_req && !req_prev) req_idx = if0.node_idx;
      else if (if0.node_req && if0.node_idx !== req_idx) idx_unstable++;
      req_prev = if0.node_req;
      if (if0.node_req) begin
        if (wait_cnt == 0) begin
          if0.node_ack   = 1'b1;
          if0.node_left  = mem_l[if0.node_idx];
          if0.node_right = mem_r[if0.node_idx];
          idx_q.push_back(if0.node_idx);
          wait_cnt = rand_dly ? int'($urandom_range(3, 0)) : 0;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  bit   hold_ready = 1'b0;
  bit   stall_done = 1'b1;
  bit   stalling;
  logic [7:0] stall_sym = 8'h00;
  int   stall_left = 0, stall_cyc = 0, stall_bad = 0;
  logic [64:0] snap;

  // Record sink for the main instance with an optional one-shot stall on a chosen symbol.
  initial begin
    if0.code_ready = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      stalling = 1'b0;
      if (stall_left > 0) begin
        stall_left--;
        stalling = 1'b1;
      end else if (if0.code_valid && if0.code_sym == stall_sym && !stall_done) begin
        stall_done = 1'b1;
        stall_left = 4;
        stalling   = 1'b1;
        snap = {if0.code_valid, mk(if0.code_sym, if0.code_bits, if0.code_len)};
      end
      if0.code_ready = !hold_ready && !stalling;
      if (stalling) begin
        stall_cyc++;
        if ({if0.code_valid, mk(if0.code_sym, if0.code_bits, if0.code_len)} !== snap) stall_bad++;
      end
      if (if0.code_valid && if0.code_ready) rec_q.push_back(mk(if0.code_sym, if0.code_bits, if0.code_len));
    end
  end

  int fetch4 = 0;
  bit done4_seen = 1'b0;

  // Memory and sink for the short-code instance: immediate ack, always ready.
  initial begin
    if4.node_ack = 1'b0; if4.node_left = '0; if4.node_right = '0; if4.code_ready = 1'b1;
    forever begin
      @(negedge clk);
      if4.node_ack = if4.node_req;
      if (if4.node_req) begin
        if4.node_left  = mem_l[if4.node_idx];
        if4.node_right = mem_r[if4.node_idx];
        fetch4++;
      end
      if (if4.code_valid) rec4_q.push_back({if4.code_sym, if4.code_bits, if4.code_len});
      if (done4) done4_seen = 1'b1;
    end
  end

  // Start a walk on the main instance and wait (bounded) for its done pulse;
  // optionally pulse start with a different root while busy.
  task automatic run_walk(input logic [6:0] root, input bit pulse, output bit got_done);
    rec_q.delete();
    idx_q.delete();
    @(negedge clk);
    root_idx = root;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got_done = 1'b0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      if (done) begin
        got_done = 1'b1;
        start = 1'b0;
      end else begin
        start    = pulse && busy && (c % 3 == 1);
        root_idx = start ? 7'd0 : root;
        @(negedge clk);
      end
    end
    start = 1'b0;
    root_idx = root;
    @(negedge clk);
  endtask

  logic [63:0] exp3 [3];
  logic [63:0] exp5 [8];
  logic [6:0]  idx5 [7];
  bit got;

  initial begin
    rst = 1'b1; start = 1'b0; start4 = 1'b0; root_idx = '0;
    for (int i = 0; i < 128; i++) begin mem_l[i] = NUL; mem_r[i] = NUL; end
    exp3[0] = mk(8'h41, 32'd0, 6'd2);
    exp3[1] = mk(8'h42, 32'd1, 6'd2);
    exp3[2] = mk(8'h43, 32'd1, 6'd1);
    for (int i = 0; i < 8; i++) exp5[i] = mk(8'(8'h60 + i), 32'(i), 6'd3);
    idx5[0] = 7'd10; idx5[1] = 7'd11; idx5[2] = 7'd13; idx5[3] = 7'd14;
    idx5[4] = 7'd12; idx5[5] = 7'd15; idx5[6] = 7'd16;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_outs", {if0.node_req, if0.code_valid, busy, done, err}, 5'b0);
    check("rst_bus", {if0.node_idx, if0.code_sym, if0.code_bits, if0.code_len}, '0);
    check("rst_outs4", {if4.node_req, if4.code_valid, busy4, done4, err4}, 5'b0);
    rst = 1'b0;
    @(negedge clk);

    // Single left leaf under the root; cycle-exact latency.
    mem_l[0] = sy(8'h41); mem_r[0] = NUL;
    rec_q.delete();
    root_idx = 7'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("t2_req_T1", {if0.node_req, busy, if0.node_idx}, {1'b1, 1'b1, 7'd0});
    @(negedge clk);
    check("t2_eval_T2", {if0.node_req, if0.code_valid}, 2'b00);
    @(negedge clk);
    check("t2_rec_T3", {if0.code_valid, mk(if0.code_sym, if0.code_bits, if0.code_len)},
          {1'b1, mk(8'h41, 32'd0, 6'd1)});
    @(negedge clk);
    check("t2_pop_T4", {if0.code_valid, done}, 2'b00);
    @(negedge clk);
    check("t2_done_T5", {done, busy}, 2'b11);
    @(negedge clk);
    check("t2_idle_T6", {done, busy, err}, 3'b000);
    check("t2_count", 64'(rec_q.size()), 64'd1);

    // Two-level tree with a stall on the second record.
    mem_l[2] = nd(1); mem_r[2] = sy(8'h43);
    mem_l[1] = sy(8'h41); mem_r[1] = sy(8'h42);
    stall_sym = 8'h42; stall_done = 1'b0; stall_cyc = 0; stall_bad = 0;
    run_walk(7'd2, 1'b0, got);
    check("t3_done", 64'(got), 64'd1);
    check("t3_busy_low", 64'(busy), 64'd0);
    check("t3_count", 64'(rec_q.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t3_rec%0d", i), (i < rec_q.size()) ? rec_q[i] : '1, exp3[i]);
    check("t3_stall_cycles", 64'(stall_cyc), 64'd5);
    check("t3_stall_stable", 64'(stall_bad), 64'd0);
    check("t3_idx_seq", {idx_q.size() == 2 ? {idx_q[0], idx_q[1]} : 14'h3fff}, {7'd2, 7'd1});

    // Reset while a record is held in EMIT, then a fresh walk from the root.
    hold_ready = 1'b1;
    rec_q.delete();
    @(negedge clk); root_idx = 7'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      if (if0.code_valid) got = 1'b1; else @(negedge clk);
    end
    check("t1_emit_reached", 64'(got), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t1_async_clear", {if0.code_valid, busy, err, if0.node_req}, 4'b0);
    @(negedge clk);
    rst = 1'b0; hold_ready = 1'b0;
    run_walk(7'd2, 1'b0, got);
    check("t1_rewalk_done", 64'(got), 64'd1);
    check("t1_rewalk_count", 64'(rec_q.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t1_rec%0d", i), (i < rec_q.size()) ? rec_q[i] : '1, exp3[i]);
    check("t1_first_idx", (idx_q.size() > 0) ? 64'(idx_q[0]) : '1, 64'd2);

    // Short-code instance: a leaf at exactly MAX_LEN is legal.
    mem_l[20] = nd(21); mem_l[21] = nd(22); mem_l[22] = nd(23); mem_l[23] = sy(8'h55);
    fetch4 = 0; rec4_q.delete(); done4_seen = 1'b0;
    @(negedge clk); root_idx = 7'd20; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      if (done4) got = 1'b1; else @(negedge clk);
    end
    check("t4a_done", {got, err4}, 2'b10);
    check("t4a_fetches", 64'(fetch4), 64'd4);
    check("t4a_rec", (rec4_q.size() == 1) ? 64'(rec4_q[0]) : '1, 64'({8'h55, 4'h0, 3'd4}));

    // One level deeper: root at depth 0 plus four descents reaches a node at depth
    // MAX_LEN whose non-null child trips the overflow.
    mem_l[23] = nd(24); mem_l[24] = sy(8'h55);
    repeat (2) @(negedge clk);
    fetch4 = 0; rec4_q.delete(); done4_seen = 1'b0;
    root_idx = 7'd20; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      if (err4) got = 1'b1; else @(negedge clk);
    end
    check("t4b_err", {got, busy4, if4.code_valid}, 3'b100);
    check("t4b_fetches", 64'(fetch4), 64'd5);
    check("t4b_no_records", 64'(rec4_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    check("t4b_err_sticky", {err4, done4_seen, busy4}, 3'b100);
    root_idx = 7'd0; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    check("t4b_err_cleared", {err4, busy4}, 2'b01);
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      if (done4) got = 1'b1; else @(negedge clk);
    end
    check("t4b_recover", (got && rec4_q.size() == 1) ? 64'(rec4_q[0]) : '1, 64'({8'h41, 4'h0, 3'd1}));

    // Full depth-3 tree with random ack delays.
    mem_l[10] = nd(11); mem_r[10] = nd(12);
    mem_l[11] = nd(13); mem_r[11] = nd(14);
    mem_l[12] = nd(15); mem_r[12] = nd(16);
    for (int i = 0; i < 4; i++) begin
      mem_l[13 + i] = sy(8'(8'h60 + 2 * i));
      mem_r[13 + i] = sy(8'(8'h61 + 2 * i));
    end
    rand_dly = 1'b1;
    run_walk(7'd10, 1'b0, got);
    check("t5_done", 64'(got), 64'd1);
    check("t5_count", 64'(rec_q.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("t5_rec%0d", i), (i < rec_q.size()) ? rec_q[i] : '1, exp5[i]);
    check("t5_idx_count", 64'(idx_q.size()), 64'd7);
    for (int i = 0; i < 7; i++)
      check($sformatf("t5_idx%0d", i), (i < idx_q.size()) ? 64'(idx_q[i]) : '1, 64'(idx5[i]));

    // Same walk with start pulsed (root 0) while busy: stream must be unchanged.
    run_walk(7'd10, 1'b1, got);
    check("t6_done", 64'(got), 64'd1);
    check("t6_count", 64'(rec_q.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("t6_rec%0d", i), (i < rec_q.size()) ? rec_q[i] : '1, exp5[i]);
    check("t6_idx_count", 64'(idx_q.size()), 64'd7);
    for (int i = 0; i < 7; i++)
      check($sformatf("t6_idx%0d", i), (i < idx_q.size()) ? 64'(idx_q[i]) : '1, 64'(idx5[i]));
    repeat (3) @(negedge clk);
    check("t6_stays_idle", {busy, if0.node_req, err}, 3'b000);
    check("node_idx_stable", 64'(idx_unstable), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
